// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM geometry constants and arbiter state encoding
package vram_arbiter_pkg;
    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 32;
    typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_DONE, SCAN_ACC} arb_state_t;
endpackage

// File: rtl/vram_arbiter_fifo.sv
// vram_pixel_fifo: synchronous scanout word FIFO with flush
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : synchronous clear (wins over push/pop)
//   i_push, i_din  : write one word
//   i_pop          : drop head word; ignored while empty
//   o_dout         : head word, 0 while empty
//   o_valid        : FIFO non-empty
//   o_occ          : occupancy 0..DEPTH
module vram_pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_occ
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_occ;
    logic             w_push, w_pop;
    assign w_pop   = i_pop && r_occ != '0;
    // a push into a full FIFO is only accepted if the head leaves the same cycle
    assign w_push  = i_push && (r_occ != (AW+1)'(DEPTH) || w_pop);
    assign o_valid = r_occ != '0;
    assign o_dout  = o_valid ? r_mem[r_rd] : '0;
    assign o_occ   = r_occ;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-ported VRAM between CPU accesses and a prefetching scanout FIFO
//   i_clk, i_rst_n                          : clock, async active-low reset
//   i_cpu_req/we/addr/wdata, o_cpu_ack/rdata : CPU request/acknowledge port
//   i_scan_en, i_frame_base, i_frame_words  : scanout control (latched on enable rise)
//   i_pix_pop, o_pix_valid, o_pix_data      : pixel pipeline FIFO read side
//   o_underrun                              : sticky pop-while-empty flag
//   o_vram_addr/n_we/n_oe/in, i_vram_out    : VRAM device interface
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WATER  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cpu_req,
    input  logic               i_cpu_we,
    input  logic [VRAM_AW-1:0] i_cpu_addr,
    input  logic [VRAM_DW-1:0] i_cpu_wdata,
    output logic               o_cpu_ack,
    output logic [VRAM_DW-1:0] o_cpu_rdata,
    input  logic               i_scan_en,
    input  logic [VRAM_AW-1:0] i_frame_base,
    input  logic [15:0]        i_frame_words,
    input  logic               i_pix_pop,
    output logic               o_pix_valid,
    output logic [VRAM_DW-1:0] o_pix_data,
    output logic               o_underrun,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic               o_vram_n_we,
    output logic               o_vram_n_oe,
    output logic [VRAM_DW-1:0] o_vram_in,
    input  logic [VRAM_DW-1:0] i_vram_out
);
    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    arb_state_t         r_state, w_next;
    logic               r_scan_en_d, w_rise, w_scan_ok, w_urgent, w_room;
    logic [VRAM_AW-1:0] r_base, w_base, r_scan_ptr;
    logic [15:0]        r_words, w_words;
    logic [OW-1:0]      w_occ;
    // in the enable-rise cycle the frame registers are not loaded yet, so use the live inputs
    assign w_rise    = i_scan_en && !r_scan_en_d;
    assign w_base    = w_rise ? i_frame_base : r_base;
    assign w_words   = w_rise ? i_frame_words : r_words;
    assign w_scan_ok = i_scan_en && w_words != '0;
    assign w_urgent  = w_scan_ok && w_occ < OW'(LOW_WATER);
    assign w_room    = w_scan_ok && w_occ < OW'(FIFO_DEPTH);
    assign o_cpu_ack = r_state == CPU_DONE;
    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE)    ? (w_urgent ? SCAN_ACC : i_cpu_req ? CPU_ACC : w_room ? SCAN_ACC : IDLE) :
                 (r_state == CPU_ACC) ? CPU_DONE : IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_scan_en_d <= 1'b0;
            r_base      <= '0;
            r_words     <= '0;
            r_scan_ptr  <= '0;
            o_vram_addr <= '0;
            o_vram_n_we <= 1'b1;
            o_vram_n_oe <= 1'b1;
            o_vram_in   <= '0;
            o_cpu_rdata <= '0;
            o_underrun  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_scan_en_d <= i_scan_en;
            if (w_rise) begin
                r_base  <= i_frame_base;
                r_words <= i_frame_words;
            end
            r_scan_ptr  <= (!i_scan_en || w_rise) ? '0 :
                           (r_state != SCAN_ACC) ? r_scan_ptr :
                           (r_scan_ptr == r_words - 16'd1) ? '0 : r_scan_ptr + 16'd1;
            o_vram_addr <= (w_next == CPU_ACC) ? i_cpu_addr :
                           (w_next == SCAN_ACC) ? w_base + r_scan_ptr : '0;
            o_vram_n_we <= !(w_next == CPU_ACC && i_cpu_we);
            o_vram_n_oe <= !(w_next == SCAN_ACC || (w_next == CPU_ACC && !i_cpu_we));
            o_vram_in   <= (w_next == CPU_ACC && i_cpu_we) ? i_cpu_wdata : '0;
            if (r_state == CPU_ACC && !o_vram_n_oe) o_cpu_rdata <= i_vram_out;
            o_underrun  <= i_scan_en && (o_underrun || (i_pix_pop && !o_pix_valid));
        end
    end
    // a fetch still in flight when scanout is disabled is dropped, not pushed
    vram_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(VRAM_DW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (!i_scan_en),
        .i_push  (r_state == SCAN_ACC && i_scan_en),
        .i_din   (i_vram_out),
        .i_pop   (i_pix_pop),
        .o_dout  (o_pix_data),
        .o_valid (o_pix_valid),
        .o_occ   (w_occ)
    );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized self-checking bench for vram_arbiter against a behavioural model
module tb_vram_arbiter;
    localparam int LOW_WATER = 2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, cpu_ack;
    logic [15:0] cpu_addr = 0;
    logic [31:0] cpu_wdata = 0, cpu_rdata;
    logic        scan_en = 0, pix_pop = 0, pix_valid, underrun;
    logic [15:0] frame_base = 0, frame_words = 0;
    logic [31:0] pix_data;
    logic [15:0] vram_addr;
    logic        vram_n_we, vram_n_oe;
    logic [31:0] vram_in, vram_out;
    logic [31:0] vmem [0:65535];
    logic [31:0] ref_wr [int];
    logic [16:0] acc_log [$];
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] s_base, s_words;
    int          s_k;

    always #5 clk = ~clk;

    vram_arbiter #(.FIFO_DEPTH(8), .LOW_WATER(LOW_WATER)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_scan_en(scan_en), .i_frame_base(frame_base), .i_frame_words(frame_words),
        .i_pix_pop(pix_pop), .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_underrun(underrun),
        .o_vram_addr(vram_addr), .o_vram_n_we(vram_n_we), .o_vram_n_oe(vram_n_oe),
        .o_vram_in(vram_in), .i_vram_out(vram_out)
    );

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    function automatic logic [31:0] exp_mem(input logic [15:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : pat(a);
    endfunction

    // VRAM device: combinational read, write on the clock edge while N_WE is low
    initial for (int i = 0; i < 65536; i++) vmem[i] = pat(16'(i));
    assign vram_out = vmem[vram_addr];
    always @(posedge clk) if (!vram_n_we) vmem[vram_addr] <= vram_in;

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (!vram_n_we && !vram_n_oe) begin
                n_bad++;
                $display("FAIL we_oe_exclusive: N_WE=%b N_OE=%b, required not both 0 at %0t", vram_n_we, vram_n_oe, $time);
            end
            if (!vram_n_we || !vram_n_oe) acc_log.push_back({!vram_n_we, vram_addr});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                              output int lat, output logic [31:0] rd);
        @(posedge clk);
        #1;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = -1; rd = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = i;
                rd = cpu_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 0;
        if (we) ref_wr[int'(addr)] = wd;
    endtask

    task automatic test_reset;
        logic [149:0] got, want;
        want = {1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b1, 32'h0};
        rst_n = 0;
        cyc(3);
        @(negedge clk);
        got = {cpu_ack, cpu_rdata, pix_valid, pix_data, underrun, vram_addr, vram_n_we, vram_n_oe, vram_in};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_values: got %h, required %h", got, want);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(3);
        @(negedge clk);
        got = {cpu_ack, cpu_rdata, pix_valid, pix_data, underrun, vram_addr, vram_n_we, vram_n_oe, vram_in};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h, required %h", got, want);
        end
    endtask

    task automatic test_cpu_rw;
        int lat;
        logic [31:0] rd;
        acc_log.delete();
        cpu_access(1'b1, 16'h0010, 32'hDEADBEEF, lat, rd);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d, required 2", lat); end
        n_cmp++;
        if (vmem[16'h0010] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_mem: got %h, required deadbeef", vmem[16'h0010]); end
        n_cmp++;
        if (acc_log.size() != 1 || acc_log[0] !== {1'b1, 16'h0010})
            begin n_bad++; $display("FAIL write_bus: %0d accesses, required one write @0010", acc_log.size()); end
        acc_log.delete();
        cpu_access(1'b0, 16'h0010, 32'h0, lat, rd);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL read_latency: got %0d, required 2", lat); end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h, required deadbeef", rd); end
        n_cmp++;
        if (acc_log.size() != 1 || acc_log[0] !== {1'b0, 16'h0010})
            begin n_bad++; $display("FAIL read_bus: %0d accesses, required one read @0010", acc_log.size()); end
        cyc(2);
        n_cmp++;
        if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h, required deadbeef", cpu_rdata); end
    endtask

    task automatic test_scan_fill;
        logic [31:0] exp;
        acc_log.delete();
        s_base = 16'h0100; s_words = 4; s_k = 0;
        frame_base = s_base; frame_words = s_words; scan_en = 1;
        cyc(40);
        n_cmp++;
        if (acc_log.size() != 8) begin n_bad++; $display("FAIL fill_count: got %0d fetches, required 8", acc_log.size()); end
        for (int j = 0; j < acc_log.size() && j < 8; j++) begin
            n_cmp++;
            if (acc_log[j] !== {1'b0, 16'(s_base + j % s_words)})
                begin n_bad++; $display("FAIL fill_addr[%0d]: got %h, required %h", j, acc_log[j], {1'b0, 16'(s_base + j % s_words)}); end
        end
        @(negedge clk);
        n_cmp++;
        if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL fill_valid: got %b, required 1", pix_valid); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pix_valid) begin
                exp = exp_mem(16'(s_base + s_k % s_words));
                n_cmp++;
                if (pix_data !== exp) begin n_bad++; $display("FAIL fill_data[%0d]: got %h, required %h", s_k, pix_data, exp); end
                s_k++;
                pix_pop = 1;
            end else pix_pop = 0;
        end
        @(posedge clk);
        #1;
        pix_pop = 0;
        n_cmp++;
        if (underrun !== 1'b0) begin n_bad++; $display("FAIL fill_underrun: got %b, required 0", underrun); end
        scan_en = 0;
        cyc(1);
        @(negedge clk);
        n_cmp++;
        if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b, required 0", pix_valid); end
    endtask

    task automatic test_wrap;
        logic [16:0] exp;
        cyc(2);
        acc_log.delete();
        frame_base = 16'hFFFE; frame_words = 4; scan_en = 1;
        cyc(30);
        n_cmp++;
        if (acc_log.size() != 8) begin n_bad++; $display("FAIL wrap_count: got %0d fetches, required 8", acc_log.size()); end
        for (int j = 0; j < acc_log.size() && j < 8; j++) begin
            exp = {1'b0, 16'(32'hFFFE + j % 4)};
            n_cmp++;
            if (acc_log[j] !== exp) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h, required %h", j, acc_log[j], exp); end
        end
        scan_en = 0;
        cyc(2);
    endtask

    task automatic test_urgent;
        int lat;
        logic [16:0] exp [3];
        exp[0] = {1'b0, 16'h0200}; exp[1] = {1'b0, 16'h0201}; exp[2] = {1'b1, 16'h4000};
        acc_log.delete();
        frame_base = 16'h0200; frame_words = 16; scan_en = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h4000; cpu_wdata = 32'hCAFE0001;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ack) begin lat = i; break; end
        end
        @(posedge clk);
        #1;
        cpu_req = 0;
        ref_wr[32'h4000] = 32'hCAFE0001;
        // from an empty FIFO, LOW_WATER urgent fetches (two cycles each) precede the CPU access
        n_cmp++;
        if (lat !== 2 + 2 * LOW_WATER) begin n_bad++; $display("FAIL urgent_latency: got %0d, required %0d", lat, 2 + 2 * LOW_WATER); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (acc_log.size() <= j || acc_log[j] !== exp[j])
                begin n_bad++; $display("FAIL urgent_order[%0d]: got %h, required %h", j, (acc_log.size() > j) ? acc_log[j] : 17'h0, exp[j]); end
        end
        n_cmp++;
        if (vmem[16'h4000] !== 32'hCAFE0001) begin n_bad++; $display("FAIL urgent_write: got %h, required cafe0001", vmem[16'h4000]); end
        scan_en = 0;
        cyc(2);
    endtask

    task automatic test_underrun;
        acc_log.delete();
        frame_base = 16'h0300; frame_words = 0; scan_en = 1;
        cyc(6);
        n_cmp++;
        if (acc_log.size() != 0) begin n_bad++; $display("FAIL zero_words: got %0d fetches, required 0", acc_log.size()); end
        pix_pop = 1;
        cyc(1);
        pix_pop = 0;
        @(negedge clk);
        n_cmp++;
        if ({underrun, pix_valid} !== 2'b10) begin n_bad++; $display("FAIL underrun_set: got underrun=%b valid=%b, required 1/0", underrun, pix_valid); end
        cyc(3);
        n_cmp++;
        if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_sticky: got %b, required 1", underrun); end
        scan_en = 0;
        cyc(1);
        @(negedge clk);
        n_cmp++;
        if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clear: got %b, required 0", underrun); end
    endtask

    task automatic test_random;
        bit done = 0;
        cyc(1);
        s_base = 16'(16'h1000 + $urandom_range(16'h2FFF));
        s_words = 16'($urandom_range(6, 1));
        s_k = 0;
        frame_base = s_base; frame_words = s_words; scan_en = 1;
        fork
            begin
                int lat;
                logic [15:0] a;
                logic [31:0] rd, exp;
                logic we;
                for (int n = 0; n < 40; n++) begin
                    we = 1'($urandom_range(1));
                    a = 16'(16'h8000 + $urandom_range(15));
                    exp = exp_mem(a);
                    cpu_access(we, a, $urandom, lat, rd);
                    n_cmp++;
                    if (lat < 2 || lat > 20) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d, required 2..20", n, lat); end
                    if (!we) begin
                        n_cmp++;
                        if (rd !== exp) begin n_bad++; $display("FAIL rand_read[%0d] @%h: got %h, required %h", n, a, rd, exp); end
                    end
                end
                done = 1;
            end
            begin
                logic [31:0] exp;
                while (!done) begin
                    @(negedge clk);
                    if (pix_valid && $urandom_range(3) == 0) begin
                        exp = exp_mem(16'(s_base + s_k % s_words));
                        n_cmp++;
                        if (pix_data !== exp) begin n_bad++; $display("FAIL rand_pix[%0d]: got %h, required %h", s_k, pix_data, exp); end
                        s_k++;
                        pix_pop = 1;
                    end else pix_pop = 0;
                end
                @(posedge clk);
                #1;
                pix_pop = 0;
            end
        join
        n_cmp++;
        if (underrun !== 1'b0 || s_k == 0) begin n_bad++; $display("FAIL rand_stream: underrun=%b pops=%0d, required 0 and >0", underrun, s_k); end
        scan_en = 0;
        cyc(2);
    endtask

    task automatic test_reset_mid;
        logic [149:0] got, want;
        bit seen = 0;
        want = {1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b1, 32'h0};
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 32'h12345678;
        @(posedge clk);
        #2;
        n_cmp++;
        if ({vram_n_we, vram_addr} !== {1'b0, 16'h0020}) begin n_bad++; $display("FAIL mid_access: got n_we=%b addr=%h, required 0/0020", vram_n_we, vram_addr); end
        rst_n = 0;
        #1;
        got = {cpu_ack, cpu_rdata, pix_valid, pix_data, underrun, vram_addr, vram_n_we, vram_n_oe, vram_in};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL mid_reset_values: got %h, required %h", got, want); end
        cpu_req = 0;
        cyc(2);
        rst_n = 1;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL aborted_ack: got an ACK, required none"); end
        n_cmp++;
        if (vmem[16'h0020] !== exp_mem(16'h0020)) begin n_bad++; $display("FAIL aborted_write: got %h, required %h", vmem[16'h0020], exp_mem(16'h0020)); end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_scan_fill();
        test_wrap();
        test_urgent();
        test_underrun();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
